// File: rtl/uart_frame_arbiter.sv
// Round-robin arbiter that serialises 24-bit words from two requesters into
// 4-byte UART frames (header byte followed by the payload, MSB first).
module uart_frame_arbiter #(
    parameter logic [7:0]  HEADER0 = 8'h41,
    parameter logic [7:0]  HEADER1 = 8'h42,
    parameter logic [15:0] TIMEOUT = 16'd20000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [23:0] data0,
    output logic        ack0,
    input  logic        req1,
    input  logic [23:0] data1,
    output logic        ack1,
    output logic        uart_transmit,
    output logic [7:0]  uart_tx_byte,
    input  logic        uart_tx_done,
    input  logic        uart_is_transmitting,
    output logic        busy,
    output logic        grant_id,
    output logic        frame_done,
    output logic        tx_error
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t      state_r, state_s;
    logic [1:0]  idx_r, idx_s;
    logic [15:0] tmo_cnt_r, tmo_cnt_s, tmo_inc_s;
    logic [23:0] data_r, data_s;
    logic        last_gnt_r, last_gnt_s;
    logic        grant_r, grant_s;
    logic        pick_s;
    logic        ack0_r, ack0_s;
    logic        ack1_r, ack1_s;
    logic        transmit_r, transmit_s;
    logic [7:0]  tx_byte_r, tx_byte_s;
    logic        frame_done_r, frame_done_s;
    logic        tx_error_r, tx_error_s;
    logic        busy_r, busy_s;

    function automatic logic [7:0] frame_byte(
        input logic [7:0]  hdr,
        input logic [23:0] payload,
        input logic [1:0]  sel
    );
        logic [7:0] b;
        case (sel)
            2'd0:    b = hdr;
            2'd1:    b = payload[23:16];
            2'd2:    b = payload[15:8];
            2'd3:    b = payload[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Round-robin pick: on a tie the requester not served last wins.
    always_comb begin
        pick_s = 1'b0;
        if (req0 && req1) begin
            pick_s = ~last_gnt_r;
        end else begin
            pick_s = req1;
        end
    end

    // Next-state and next-output logic for the framing FSM.
    always_comb begin
        state_s      = state_r;
        idx_s        = idx_r;
        tmo_cnt_s    = tmo_cnt_r;
        tmo_inc_s    = tmo_cnt_r + 16'd1;
        data_s       = data_r;
        last_gnt_s   = last_gnt_r;
        grant_s      = grant_r;
        tx_byte_s    = tx_byte_r;
        ack0_s       = 1'b0;
        ack1_s       = 1'b0;
        transmit_s   = 1'b0;
        frame_done_s = 1'b0;
        tx_error_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (req0 || req1) begin
                    state_s    = SEND;
                    idx_s      = 2'd0;
                    last_gnt_s = pick_s;
                    grant_s    = pick_s;
                    if (pick_s) begin
                        ack1_s = 1'b1;
                        data_s = data1;
                    end else begin
                        ack0_s = 1'b1;
                        data_s = data0;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            SEND: begin
                if (!uart_is_transmitting) begin
                    state_s    = WAIT_DONE;
                    transmit_s = 1'b1;
                    tx_byte_s  = frame_byte(grant_r ? HEADER1 : HEADER0, data_r, idx_r);
                    tmo_cnt_s  = 16'd0;
                end else begin
                    state_s = SEND;
                end
            end
            WAIT_DONE: begin
                // A done arriving on the timeout cycle still wins.
                if (uart_tx_done) begin
                    if (idx_r == 2'd3) begin
                        frame_done_s = 1'b1;
                        state_s      = IDLE;
                    end else begin
                        idx_s   = idx_r + 2'd1;
                        state_s = SEND;
                    end
                end else if (tmo_inc_s == TIMEOUT) begin
                    tx_error_s = 1'b1;
                    state_s    = IDLE;
                end else begin
                    tmo_cnt_s = tmo_inc_s;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    // State and registered-output flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            idx_r        <= 2'd0;
            tmo_cnt_r    <= 16'd0;
            data_r       <= 24'd0;
            last_gnt_r   <= 1'b1;
            grant_r      <= 1'b0;
            ack0_r       <= 1'b0;
            ack1_r       <= 1'b0;
            transmit_r   <= 1'b0;
            tx_byte_r    <= 8'h00;
            frame_done_r <= 1'b0;
            tx_error_r   <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            idx_r        <= idx_s;
            tmo_cnt_r    <= tmo_cnt_s;
            data_r       <= data_s;
            last_gnt_r   <= last_gnt_s;
            grant_r      <= grant_s;
            ack0_r       <= ack0_s;
            ack1_r       <= ack1_s;
            transmit_r   <= transmit_s;
            tx_byte_r    <= tx_byte_s;
            frame_done_r <= frame_done_s;
            tx_error_r   <= tx_error_s;
            busy_r       <= busy_s;
        end
    end

    assign ack0          = ack0_r;
    assign ack1          = ack1_r;
    assign uart_transmit = transmit_r;
    assign uart_tx_byte  = tx_byte_r;
    assign busy          = busy_r;
    assign grant_id      = grant_r;
    assign frame_done    = frame_done_r;
    assign tx_error      = tx_error_r;

endmodule

// File: doc/uart_frame_arbiter.md
UART_FRAME_ARBITER -- requirements
Module: uart_frame_arbiter

Interface
REQ-001 Parameter: HEADER0, default 8'h41, header byte prefixed to frames from requester 0.
REQ-002 Parameter: HEADER1, default 8'h42, header byte prefixed to frames from requester 1.
REQ-003 Parameter: TIMEOUT, default 16'd20000, maximum clk cycles to wait for uart_tx_done per byte.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 Port: clk  in  1  master clock; all logic on posedge.
REQ-006 Port: rst  in  1  synchronous reset, active-high.
REQ-007 Port: req0  in  1  requester 0 has a 24-bit word to send; held until ack0.
REQ-008 Port: data0  in  24  requester 0 payload; stable while req0 high.
REQ-009 Port: ack0  out  1  one-cycle pulse; data0 latched.
REQ-010 Port: req1  in  1  requester 1 request, same rules as req0.
REQ-011 Port: data1  in  24  requester 1 payload.
REQ-012 Port: ack1  out  1  one-cycle pulse; data1 latched.
REQ-013 Port: uart_transmit  out  1  one-cycle start pulse to the UART transmitter.
REQ-014 Port: uart_tx_byte  out  8  byte to the UART; held stable from the start pulse until the next load.
REQ-015 Port: uart_tx_done  in  1  UART one-cycle pulse after stop bit.
REQ-016 Port: uart_is_transmitting  in  1  UART transmitter busy.
REQ-017 Port: busy  out  1  high whenever state != IDLE.
REQ-018 Port: grant_id  out  1  requester owning the current or last frame.
REQ-019 Port: frame_done  out  1  one-cycle pulse when the 4th byte's uart_tx_done is seen.
REQ-020 Port: tx_error  out  1  one-cycle pulse when a frame is aborted on timeout.

Function
REQ-021 Frame SHALL be 4 bytes in order: header (HEADER0/HEADER1 per grant), data[23:16], data[15:8], data[7:0].
REQ-022 States SHALL be IDLE, SEND, WAIT_DONE; byte index idx is 2 bits, 0..3.
REQ-023 IDLE: when any req is high at a clk edge, the block SHALL grant one requester, latch its data, pulse its ack, set grant_id, set idx=0, and go to SEND.
REQ-024 Arbitration SHALL be round-robin: if both req are high, grant the requester not granted last; a single requester is granted regardless.
REQ-025 The last-grant pointer SHALL update only on a grant; a requester dropping req before ack SHALL NOT be served.
REQ-026 SEND: if uart_is_transmitting=0, the block SHALL drive uart_tx_byte with byte idx, pulse uart_transmit for one cycle, clear the timeout counter, and go to WAIT_DONE; otherwise it SHALL stay in SEND.
REQ-027 Latency: ack at cycle N SHALL be followed by uart_transmit at N+1 when the UART is idle.
REQ-028 WAIT_DONE: on uart_tx_done with idx<3, the block SHALL increment idx and go to SEND.
REQ-029 WAIT_DONE: on uart_tx_done with idx==3, the block SHALL pulse frame_done and go to IDLE.
REQ-030 In WAIT_DONE the timeout counter SHALL increment each cycle; on reaching TIMEOUT without uart_tx_done, the block SHALL pulse tx_error and go to IDLE, discarding the remaining bytes.
REQ-031 uart_tx_done and timeout in the same cycle SHALL be treated as done.
REQ-032 uart_tx_done seen in IDLE or SEND SHALL be ignored.
REQ-033 A new grant SHALL be possible in the cycle after frame_done or tx_error.
REQ-034 ack0 and ack1 SHALL never be high in the same cycle; at most one uart_transmit pulse SHALL occur per byte.

Reset
REQ-035 On rst, the block SHALL set state=IDLE, idx=0, the timeout counter to 0, the last-grant pointer to 1 (requester 0 wins the first tie), and ack0, ack1, uart_transmit, frame_done, tx_error, busy, and grant_id to 0; uart_tx_byte SHALL be set to 8'h00.
REQ-036 Reset mid-frame SHALL abandon the frame with no ack or frame_done; because of REQ-026, the next frame SHALL wait for a UART still finishing its byte.

Verification
REQ-037 Single frame: req0=1 with data0=24'h123456 and the UART model idle -> ack0 pulse, then bytes 41,12,34,56 each with one uart_transmit pulse, frame_done after the 4th done, busy low after.
REQ-038 Contention: req0 and req1 both high from reset -> req0 frame first (header 41); req1 frame second (header 42); repeated contention alternates.
REQ-039 Busy UART: hold uart_is_transmitting=1 for 100 cycles after ack -> uart_transmit held off until it falls, then issued the next cycle.
REQ-040 Timeout: TIMEOUT=16'd50, suppress uart_tx_done after byte 2 -> tx_error pulse exactly 50 cycles after that byte's uart_transmit, no frame_done, return to IDLE.
REQ-041 Reset mid-frame: rst asserted during byte 2 -> all outputs 0 the next cycle; a subsequent req1 is served with header 42 starting at byte 0.
REQ-042 Coincidence: uart_tx_done on the same cycle the timeout count reaches TIMEOUT -> byte accepted, no tx_error.
